// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator controller blocks.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS_DEF = 8;
  localparam int unsigned FLOOR_W_DEF    = 3;
  localparam int unsigned MOVE_TICKS_DEF = 2;
  localparam int unsigned DOOR_TICKS_DEF = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DOOR   = 2'd2
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_edge.sv
// Rising-edge detector for a slow level sampled in the clk domain.
module tick_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse_c
);

  logic level_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_d <= 1'b0;
    else       level_d <= level;
  end

  assign pulse_c = level & ~level_d;

endmodule

// File: rtl/elevator_sched.sv
// SCAN car scheduler: latches calls, moves floor by floor on 1 Hz ticks,
// and sequences the door dwell.
module elevator_sched
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int unsigned FLOOR_W    = FLOOR_W_DEF,
  parameter int unsigned MOVE_TICKS = MOVE_TICKS_DEF,
  parameter int unsigned DOOR_TICKS = DOOR_TICKS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_1Hz,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned TMR_W = $clog2(max_u(MOVE_TICKS, DOOR_TICKS) + 1);
  localparam logic [TMR_W-1:0] MOVE_LOAD = TMR_W'(MOVE_TICKS);
  localparam logic [TMR_W-1:0] DOOR_LOAD = TMR_W'(DOOR_TICKS);

  state_t                  state, state_n;
  logic [TMR_W-1:0]        timer, timer_n, timer_dec;
  logic [FLOOR_W-1:0]      floor_n, step_floor;
  logic                    dir_n;
  logic [NUM_FLOORS-1:0]   pend_n, pend_l, floor_oh, next_oh;
  logic                    tick_c, same_floor_req, above, below, here;

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0]    f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++)
      if (i > int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0]    f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++)
      if (i < int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  tick_edge u_tick (
    .clk     (clk),
    .reset   (reset),
    .level   (clk_1Hz),
    .pulse_c (tick_c)
  );

  assign floor_oh       = NUM_FLOORS'(1) << current_floor;
  assign step_floor     = dir_up ? current_floor + FLOOR_W'(1) : current_floor - FLOOR_W'(1);
  assign next_oh        = NUM_FLOORS'(1) << step_floor;
  assign timer_dec      = timer - TMR_W'(1);
  assign same_floor_req = (state == DOOR) && ((req & floor_oh) != '0);
  // With the door open, a call at this floor extends the dwell instead of queuing.
  assign pend_l         = pending | ((state == DOOR) ? (req & ~floor_oh) : req);
  assign above          = any_above(pending, current_floor);
  assign below          = any_below(pending, current_floor);
  assign here           = (pending & floor_oh) != '0;

  // Next-state and datapath decisions.
  always_comb begin
    state_n = state;
    timer_n = timer;
    floor_n = current_floor;
    dir_n   = dir_up;
    pend_n  = pend_l;
    case (state)
      IDLE: begin
        if (here) begin
          state_n = DOOR;
          pend_n  = pend_l & ~floor_oh;
          timer_n = DOOR_LOAD;
        end else if (above && (dir_up || !below)) begin
          dir_n   = 1'b1;
          state_n = MOVING;
          timer_n = MOVE_LOAD;
        end else if (below) begin
          dir_n   = 1'b0;
          state_n = MOVING;
          timer_n = MOVE_LOAD;
        end
      end
      MOVING: begin
        if (tick_c) begin
          timer_n = timer_dec;
          // Arrival: decide against the floor just reached.
          if (timer_dec == '0) begin
            floor_n = step_floor;
            if ((pend_l & next_oh) != '0) begin
              state_n = DOOR;
              pend_n  = pend_l & ~next_oh;
              timer_n = DOOR_LOAD;
            end else if (dir_up ? any_above(pend_l, step_floor)
                                : any_below(pend_l, step_floor)) begin
              timer_n = MOVE_LOAD;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      DOOR: begin
        if (same_floor_req) begin
          timer_n = DOOR_LOAD;
        end else if (tick_c) begin
          timer_n = timer_dec;
          if (timer_dec == '0) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      current_floor <= '0;
      dir_up        <= 1'b1;
      pending       <= '0;
      moving        <= 1'b0;
      door_open     <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      current_floor <= floor_n;
      dir_up        <= dir_n;
      pending       <= pend_n;
      moving        <= (state_n == MOVING);
      door_open     <= (state_n == DOOR);
    end
  end

endmodule

// File: tb/tb_elevator_sched.sv
// Bench for elevator_sched: vector table, corner sequences and a random run
// against a behavioural model.
module tb_elevator_sched;

  localparam int NF     = 8;
  localparam int MOVE_T = 2;
  localparam int DOOR_T = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_1Hz;
  logic [7:0] req;
  logic [2:0] current_floor;
  logic       dir_up, moving, door_open;
  logic [7:0] pending;

  int total = 0;
  int bad   = 0;

  elevator_sched dut (
    .clk           (clk),
    .reset         (reset),
    .clk_1Hz       (clk_1Hz),
    .req           (req),
    .current_floor (current_floor),
    .dir_up        (dir_up),
    .moving        (moving),
    .door_open     (door_open),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 travelling, 2 door open.
  bit m_pend[NF];
  int m_floor, m_mode, m_timer;
  bit m_dir, m_prev, m_tk, m_here, m_ab, m_be;

  function automatic bit m_ahead(input int f, input bit up);
    for (int i = 0; i < NF; i++)
      if (m_pend[i] && (up ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_pvec();
    logic [7:0] r;
    for (int i = 0; i < NF; i++) r[i] = m_pend[i];
    return r;
  endfunction

  task automatic model_step();
    if (reset) begin
      for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
      m_floor = 0; m_mode = 0; m_timer = 0; m_dir = 1'b1; m_prev = 1'b0;
    end else begin
      m_tk   = clk_1Hz && !m_prev;
      m_prev = clk_1Hz;
      m_here = m_pend[m_floor];
      m_ab   = m_ahead(m_floor, 1'b1);
      m_be   = m_ahead(m_floor, 1'b0);
      for (int i = 0; i < NF; i++)
        if (req[i] && !(m_mode == 2 && i == m_floor)) m_pend[i] = 1'b1;
      if (m_mode == 0) begin
        if (m_here) begin
          m_mode = 2; m_pend[m_floor] = 1'b0; m_timer = DOOR_T;
        end else if (m_ab && (m_dir || !m_be)) begin
          m_dir = 1'b1; m_mode = 1; m_timer = MOVE_T;
        end else if (m_be) begin
          m_dir = 1'b0; m_mode = 1; m_timer = MOVE_T;
        end
      end else if (m_mode == 1) begin
        if (m_tk) begin
          m_timer--;
          if (m_timer == 0) begin
            m_floor += m_dir ? 1 : -1;
            if (m_pend[m_floor]) begin
              m_mode = 2; m_pend[m_floor] = 1'b0; m_timer = DOOR_T;
            end else if (m_ahead(m_floor, m_dir)) begin
              m_timer = MOVE_T;
            end else begin
              m_mode = 0;
            end
          end
        end
      end else begin
        if (req[m_floor]) m_timer = DOOR_T;
        else if (m_tk) begin
          m_timer--;
          if (m_timer == 0) m_mode = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // Model comparison every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check("m.floor",   32'(current_floor), 32'(m_floor));
      check("m.dir",     32'(dir_up),        32'(m_dir));
      check("m.moving",  32'(moving),        32'(m_mode == 1));
      check("m.door",    32'(door_open),     32'(m_mode == 2));
      check("m.pending", 32'(pending),       32'(m_pvec()));
    end
  end

  // The car must never jump or wrap past the end floors.
  int prev_floor = -1;
  initial forever begin
    @(posedge reset);
    prev_floor = -1;
  end
  initial forever begin
    @(negedge clk);
    if (reset) prev_floor = -1;
    else begin
      if (prev_floor >= 0) begin
        int d;
        d = int'(current_floor) - prev_floor;
        check("floor_step", 32'(d >= -1 && d <= 1), 32'(1));
      end
      prev_floor = int'(current_floor);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    clk_1Hz = 1'b1; cyc(1);
    clk_1Hz = 1'b0; cyc(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic expect_out(input string tag, input logic [2:0] f, input logic d,
                            input logic mv, input logic dr, input logic [7:0] p);
    check({tag, ".floor"},   32'(current_floor), 32'(f));
    check({tag, ".dir"},     32'(dir_up),        32'(d));
    check({tag, ".moving"},  32'(moving),        32'(mv));
    check({tag, ".door"},    32'(door_open),     32'(dr));
    check({tag, ".pending"}, 32'(pending),       32'(p));
  endtask

  typedef struct {
    logic [7:0] req;
    int         nticks;
    int         settle;
    logic [2:0] floor;
    logic       dir;
    logic       mv;
    logic       door;
    logic [7:0] pend;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int hold;
    tbl[0]  = '{8'h08, 0,  1, 3'd0, 1'b1, 1'b1, 1'b0, 8'h08};
    tbl[1]  = '{8'h00, 2,  0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h08};
    tbl[2]  = '{8'h00, 2,  0, 3'd2, 1'b1, 1'b1, 1'b0, 8'h08};
    tbl[3]  = '{8'h00, 2,  0, 3'd3, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[4]  = '{8'h00, 2,  0, 3'd3, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[5]  = '{8'h00, 1,  0, 3'd3, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{8'h08, 0,  1, 3'd3, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[7]  = '{8'h00, 2,  0, 3'd3, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[8]  = '{8'h08, 2,  0, 3'd3, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[9]  = '{8'h00, 1,  0, 3'd3, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{8'h41, 0,  1, 3'd3, 1'b1, 1'b1, 1'b0, 8'h41};
    tbl[11] = '{8'h00, 6,  0, 3'd6, 1'b1, 1'b0, 1'b1, 8'h01};
    tbl[12] = '{8'h00, 3,  0, 3'd6, 1'b0, 1'b1, 1'b0, 8'h01};
    tbl[13] = '{8'h00, 12, 0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[14] = '{8'h00, 3,  0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00};

    reset = 1'b1; clk_1Hz = 1'b0; req = 8'h00;
    cyc(1);
    expect_out("reset", 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(2);
    reset = 1'b0;
    cyc(2);

    // Single call, same-floor call, door reload, SCAN up then down.
    for (int k = 0; k < 15; k++) begin
      req = tbl[k].req; cyc(1); req = 8'h00;
      ticks(tbl[k].nticks);
      cyc(tbl[k].settle);
      expect_out($sformatf("step%0d", k), tbl[k].floor, tbl[k].dir,
                 tbl[k].mv, tbl[k].door, tbl[k].pend);
    end

    // Stuck-high 1 Hz level: only one tick.
    req = 8'h02; cyc(1); req = 8'h00; cyc(1);
    clk_1Hz = 1'b1; cyc(1000);
    expect_out("stuck", 3'd0, 1'b1, 1'b1, 1'b0, 8'h02);
    clk_1Hz = 1'b0; cyc(1);
    do_tick();
    expect_out("stuck_arrive", 3'd1, 1'b1, 1'b0, 1'b1, 8'h00);
    ticks(3);

    // Asynchronous reset mid-move between floors 2 and 3.
    req = 8'h90; cyc(1); req = 8'h00; cyc(1);
    ticks(3);
    expect_out("premove", 3'd2, 1'b1, 1'b1, 1'b0, 8'h90);
    @(posedge clk); #3 reset = 1'b1;
    #1 expect_out("async_rst", 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk); reset = 1'b0;
    ticks(4); cyc(5);
    expect_out("post_rst", 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);

    // SCAN: calls behind and ahead while travelling up.
    req = 8'h20; cyc(1); req = 8'h00; cyc(1);
    ticks(4);
    req = 8'h12; cyc(1); req = 8'h00;
    expect_out("scan_mid", 3'd2, 1'b1, 1'b1, 1'b0, 8'h32);
    ticks(4);
    expect_out("scan_f4", 3'd4, 1'b1, 1'b0, 1'b1, 8'h22);
    ticks(3);
    expect_out("scan_go5", 3'd4, 1'b1, 1'b1, 1'b0, 8'h22);
    ticks(2);
    expect_out("scan_f5", 3'd5, 1'b1, 1'b0, 1'b1, 8'h02);
    ticks(3);
    expect_out("scan_rev", 3'd5, 1'b0, 1'b1, 1'b0, 8'h02);
    ticks(8);
    expect_out("scan_f1", 3'd1, 1'b0, 1'b0, 1'b1, 8'h00);

    // Random traffic, checked by the model process.
    hold = 1;
    for (int c = 0; c < 4000; c++) begin
      hold--;
      if (hold <= 0) begin
        clk_1Hz = ~clk_1Hz;
        hold = int'($urandom_range(1, 4));
      end
      req = ($urandom_range(0, 19) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      cyc(1);
    end
    req = 8'h00;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
